// File: rtl/param_cpu_pkg.sv
// Shared opcode, state and field definitions for the parametrised multi-cycle CPU.
// Optional MUL support is controlled by the CPU_MUL_EN macro.
package param_cpu_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'd0;
    localparam logic [OPC_W-1:0] OP_LDI  = 4'd1;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'd2;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'd3;
    localparam logic [OPC_W-1:0] OP_AND  = 4'd4;
    localparam logic [OPC_W-1:0] OP_OR   = 4'd5;
    localparam logic [OPC_W-1:0] OP_XOR  = 4'd6;
    localparam logic [OPC_W-1:0] OP_MOV  = 4'd7;
    localparam logic [OPC_W-1:0] OP_OUT  = 4'd8;
    localparam logic [OPC_W-1:0] OP_JNZ  = 4'd9;
    localparam logic [OPC_W-1:0] OP_MUL  = 4'd10;
    localparam logic [OPC_W-1:0] OP_HALT = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_WB,
        ST_DONE
    } state_e;

    // Opcodes whose ALU result updates carry/zero.
    function automatic logic sets_flags(input logic [OPC_W-1:0] op);
        logic f;
        f = (op >= OP_ADD) && (op <= OP_MOV);
`ifdef CPU_MUL_EN
        if (op == OP_MUL) f = 1'b1;
`endif
        return f;
    endfunction

    function automatic logic writes_reg(input logic [OPC_W-1:0] op);
        return (op == OP_LDI) || sets_flags(op);
    endfunction

endpackage

// File: rtl/param_cpu_alu.sv
// Combinational ALU for the parametrised CPU; MUL exists only when CPU_MUL_EN is defined.
module param_cpu_alu
    import param_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [OPC_W-1:0]  op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y,
    output logic              carry
);

    logic [DATA_W:0] sum;
    assign sum = {1'b0, a} + {1'b0, b};

`ifdef CPU_MUL_EN
    logic [2*DATA_W-1:0] prod;
    assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`endif

    always_comb begin
        y     = a;
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                y     = sum[DATA_W-1:0];
                carry = sum[DATA_W];
            end
            OP_SUB: begin
                y     = a - b;
                carry = (a < b);
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_MOV: y = b;
`ifdef CPU_MUL_EN
            OP_MUL: begin
                y     = prod[DATA_W-1:0];
                carry = |prod[2*DATA_W-1:DATA_W];
            end
`endif
            default: begin
                y     = a;
                carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/param_cpu_data_path.sv
// Multi-cycle FETCH/EXEC/WB CPU with external combinational ROM and NUM_REGS register file.
// Build with CPU_MUL_EN defined to enable opcode 10 (MUL).
module param_cpu_data_path
    import param_cpu_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NUM_REGS   = 4,
    parameter int PROG_DEPTH = 16,
    localparam int RA_W = $clog2(NUM_REGS),
    localparam int PC_W = $clog2(PROG_DEPTH),
    localparam int IR_W = OPC_W + 2*RA_W + DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [PC_W-1:0]   instr_addr,
    input  logic [IR_W-1:0]   instr_data,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic [1:0]        flags,
    output logic              done
);

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [IR_W-1:0]     ir_q, ir_d;
    logic [DATA_W-1:0]   alu_q, alu_d;
    logic                carry_q, carry_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                result_valid_q, result_valid_d;
    logic [1:0]          flags_q, flags_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic                reg_we;

    logic [OPC_W-1:0]  op;
    logic [RA_W-1:0]   rd, rs;
    logic [DATA_W-1:0] imm, rd_val, rs_val, alu_y;
    logic              alu_c;

    assign op     = ir_q[IR_W-1 -: OPC_W];
    assign rd     = ir_q[DATA_W+2*RA_W-1 -: RA_W];
    assign rs     = ir_q[DATA_W+RA_W-1 -: RA_W];
    assign imm    = ir_q[DATA_W-1:0];
    assign rd_val = regs_q[rd];
    assign rs_val = regs_q[rs];

    param_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op    (op),
        .a     (rd_val),
        .b     (rs_val),
        .y     (alu_y),
        .carry (alu_c)
    );

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ir_d           = ir_q;
        alu_d          = alu_q;
        carry_d        = carry_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        flags_d        = flags_q;
        done_d         = done_q;
        reg_we         = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                    done_d  = 1'b0;
                end
            end
            ST_FETCH: begin
                ir_d    = instr_data;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                alu_d   = (op == OP_LDI) ? imm : alu_y;
                carry_d = alu_c;
                // OUT is registered here so the valid pulse lands in the WB cycle.
                if (op == OP_OUT) begin
                    result_d       = rd_val;
                    result_valid_d = 1'b1;
                end
                state_d = ST_WB;
            end
            ST_WB: begin
                if (op == OP_HALT) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    reg_we = writes_reg(op);
                    if (sets_flags(op)) flags_d = {carry_q, (alu_q == '0)};
                    if ((op == OP_JNZ) && (rd_val != '0)) pc_d = imm[PC_W-1:0];
                    else                                  pc_d = pc_q + PC_W'(1);
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
        assign regs_d[gi] = (reg_we && (rd == RA_W'(gi))) ? alu_q : regs_q[gi];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) regs_q[gi] <= '0;
            else        regs_q[gi] <= regs_d[gi];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            pc_q           <= '0;
            ir_q           <= '0;
            alu_q          <= '0;
            carry_q        <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            flags_q        <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            ir_q           <= ir_d;
            alu_q          <= alu_d;
            carry_q        <= carry_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            flags_q        <= flags_d;
            done_q         <= done_d;
        end
    end

    assign instr_addr   = pc_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign flags        = flags_q;
    assign done         = done_q;

endmodule

// File: tb/tb_param_cpu_data_path.sv
// Scoreboard bench: an instruction-level model predicts OUT values, flags and cycle counts.
module tb_param_cpu_data_path;

    localparam int DATA_W     = 8;
    localparam int NUM_REGS   = 4;
    localparam int PROG_DEPTH = 16;
    localparam int RA_W       = 2;
    localparam int PC_W       = 4;
    localparam int IR_W       = 4 + 2*RA_W + DATA_W;
    localparam int MODV       = 1 << DATA_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic [PC_W-1:0]   instr_addr;
    logic [IR_W-1:0]   instr_data;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic [1:0]        flags;
    logic              done;

    logic [IR_W-1:0] rom [PROG_DEPTH];
    assign instr_data = rom[instr_addr];

    param_cpu_data_path #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .PROG_DEPTH(PROG_DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .instr_addr   (instr_addr),
        .instr_data   (instr_data),
        .result       (result),
        .result_valid (result_valid),
        .flags        (flags),
        .done         (done)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_q[$];
    int m_regs[NUM_REGS];
    bit m_c, m_z;
    int m_result;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every result_valid pulse must match the next predicted OUT value.
    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_result_valid: got result %0d, expected no pulse", result);
            end else begin
                check("out_value", int'(result), exp_q.pop_front());
            end
        end
    end

    function automatic logic [IR_W-1:0] enc(input int op, input int rd, input int rs, input int imm);
        logic [3:0] o; logic [RA_W-1:0] d, s; logic [DATA_W-1:0] i;
        o = op[3:0]; d = rd[RA_W-1:0]; s = rs[RA_W-1:0]; i = imm[DATA_W-1:0];
        return {o, d, s, i};
    endfunction

    task automatic fill(input int op);
        for (int i = 0; i < PROG_DEPTH; i++) rom[i] = enc(op, 0, 0, 0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 0;
        m_c = 0; m_z = 0; m_result = 0;
        exp_q.delete();
    endtask

    task automatic upd(input int rd, input int v, input bit c);
        m_regs[rd] = v;
        m_c = c;
        m_z = (v == 0);
    endtask

    // Instruction-level interpretation of the ROM; pushes predicted OUT values.
    task automatic model_run(output int steps, output bit halted);
        int pc, npc, op, rd, rs, imm, a, b;
        logic [IR_W-1:0] w;
        pc = 0; steps = 0; halted = 0;
        while (steps < 200 && !halted) begin
            w   = rom[pc];
            op  = int'(w[IR_W-1 -: 4]);
            rd  = int'(w[DATA_W+2*RA_W-1 -: RA_W]);
            rs  = int'(w[DATA_W+RA_W-1 -: RA_W]);
            imm = int'(w[DATA_W-1:0]);
            a = m_regs[rd]; b = m_regs[rs];
            npc = (pc + 1) % PROG_DEPTH;
            steps++;
            case (op)
                1:  m_regs[rd] = imm;
                2:  upd(rd, (a + b) % MODV, (a + b) >= MODV);
                3:  upd(rd, (a - b + MODV) % MODV, a < b);
                4:  upd(rd, a & b, 0);
                5:  upd(rd, a | b, 0);
                6:  upd(rd, a ^ b, 0);
                7:  upd(rd, b, 0);
                8:  begin exp_q.push_back(a); m_result = a; end
                9:  if (a != 0) npc = imm % PROG_DEPTH;
`ifdef CPU_MUL_EN
                10: upd(rd, (a * b) % MODV, (a * b) >= MODV);
`endif
                15: halted = 1;
                default: ;
            endcase
            pc = npc;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Runs the ROM to HALT; exp_res < 0 means rely on the model only.
    task automatic run_prog(input string name, input int exp_res);
        int steps, cyc, n_out;
        bit halted;
        n_out = exp_q.size();
        model_run(steps, halted);
        n_out = exp_q.size() - n_out;
        pulse_start();
        cyc = 0;
        while (done !== 1'b1 && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "_done"}, int'(done), 1);
        check({name, "_cycles"}, cyc, 3 * steps);
        check({name, "_flags"}, int'(flags), int'({m_c, m_z}));
        check({name, "_result_hold"}, int'(result), m_result);
        check({name, "_pending_outs"}, exp_q.size(), 0);
        if (exp_res >= 0) check({name, "_result_ref"}, int'(result), exp_res);
        $display("prog %s: instr=%0d cycles=%0d outs=%0d result=%0d flags=%b",
                 name, steps, cyc, n_out, result, flags);
    endtask

    task automatic gen_random();
        int len, pick, op, imm;
        fill(15);
        len = $urandom_range(3, 14);
        for (int i = 0; i < len; i++) begin
            pick = $urandom_range(0, 10);
            imm  = $urandom_range(0, MODV - 1);
            case (pick)
                0, 1: op = 1;
                2, 3, 4, 5, 6, 7: op = pick;
                8: op = 8;
                9: op = 10;
                default: begin
                    if ($urandom_range(0, 1) == 1) begin
                        op  = 9;
                        imm = $urandom_range(i + 1, len);
                    end else begin
                        op = (int'($urandom_range(0, 4)) == 0) ? 0 : 10 + int'($urandom_range(1, 4));
                    end
                end
            endcase
            rom[i] = enc(op, $urandom_range(0, 3), $urandom_range(0, 3), imm);
        end
    endtask

    task automatic load_add();
        fill(15);
        rom[0] = enc(1, 0, 0, 5);
        rom[1] = enc(1, 1, 0, 3);
        rom[2] = enc(2, 0, 1, 0);
        rom[3] = enc(8, 0, 0, 0);
    endtask

    initial begin
        fill(0);
        model_reset();
        #3 rst_n = 1'b0;
        #1;
        check("rst_instr_addr", int'(instr_addr), 0);
        check("rst_result", int'(result), 0);
        check("rst_result_valid", int'(result_valid), 0);
        check("rst_flags", int'(flags), 0);
        check("rst_done", int'(done), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        load_add();
        run_prog("add", 8);

        fill(15);
        rom[0] = enc(1, 0, 0, 2);
        rom[1] = enc(1, 1, 0, 3);
        rom[2] = enc(3, 0, 1, 0);
        rom[3] = enc(8, 0, 0, 0);
        run_prog("sub_borrow", 255);
        check("sub_borrow_flags_ref", int'(flags), 2);

        fill(15);
        rom[0] = enc(3, 0, 0, 0);
        rom[1] = enc(8, 0, 0, 0);
        run_prog("sub_self", 0);
        check("sub_self_flags_ref", int'(flags), 1);

        fill(15);
        rom[0] = enc(1, 0, 0, 3);
        rom[1] = enc(1, 1, 0, 1);
        rom[2] = enc(3, 0, 1, 0);
        rom[3] = enc(9, 0, 0, 2);
        rom[4] = enc(8, 0, 0, 0);
        run_prog("loop", 0);
        check("loop_flags_ref", int'(flags), 1);

        fill(15);
        rom[0] = enc(1, 0, 0, 7);
        rom[1] = enc(1, 1, 0, 9);
        rom[2] = enc(10, 0, 1, 0);
        rom[3] = enc(8, 0, 0, 0);
`ifdef CPU_MUL_EN
        run_prog("mul", 63);
`else
        run_prog("mul", 7);
`endif

        for (int t = 0; t < 30; t++) begin
            gen_random();
            run_prog($sformatf("rand%0d", t), -1);
        end

        // All-NOP ROM: pc walks every 3 cycles and wraps; starts while busy are ignored.
        fill(0);
        pulse_start();
        check("nop_pc_0", int'(instr_addr), 0);
        for (int k = 1; k <= 20; k++) begin
            if (k == 5 || k == 12) start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check($sformatf("nop_pc_%0d", k), int'(instr_addr), k % PROG_DEPTH);
        end
        check("nop_done", int'(done), 0);
        $display("prog nop_wrap: pc sequence checked over 20 instructions");

        // Reset mid-ADD, then prove the register file was cleared.
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        model_reset();
        load_add();
        pulse_start();
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_instr_addr", int'(instr_addr), 0);
        check("abort_result", int'(result), 0);
        check("abort_result_valid", int'(result_valid), 0);
        check("abort_flags", int'(flags), 0);
        check("abort_done", int'(done), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        model_reset();
        $display("reset during EXEC of ADD applied and released");

        fill(15);
        rom[0] = enc(8, 0, 0, 0);
        rom[1] = enc(8, 1, 0, 0);
        rom[2] = enc(2, 0, 1, 0);
        rom[3] = enc(8, 0, 0, 0);
        run_prog("post_reset_regs", 0);
        check("post_reset_flags_ref", int'(flags), 1);

        load_add();
        run_prog("add_rerun", 8);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
